// File: rtl/rs_pkg.sv
// Shared definitions for the reservation station.
// Holds the ALU operation encodings, the default data/tag widths and the
// layout of one reservation-station entry at those default widths.
package rs_pkg;

    localparam int RS_XLEN  = 32;
    localparam int RS_TAG_W = 4;
    localparam int RS_OP_W  = 4;

    typedef enum logic [RS_OP_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

    // Entry layout at the default widths. The parametrised top keeps the same
    // fields as separate arrays so XLEN/TAG_W/OP_W can be overridden.
    typedef struct packed {
        logic                busy;
        logic [RS_OP_W-1:0]  op;
        logic [RS_XLEN-1:0]  vj;
        logic [RS_XLEN-1:0]  vk;
        logic                qj_busy;
        logic [RS_TAG_W-1:0] qj;
        logic                qk_busy;
        logic [RS_TAG_W-1:0] qk;
        logic [RS_XLEN-1:0]  imm;
        logic [RS_TAG_W-1:0] rob;
    } rs_entry_t;

endpackage

// File: rtl/rs_find_first.sv
// Lowest-index priority encoder.
// Ports:
//   req   - request vector, bit 0 has highest priority
//   found - at least one request bit is set
//   idx   - index of the lowest set bit (0 when nothing is set)
module rs_find_first #(
    parameter int N  = 16,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    output logic          found,
    output logic [IW-1:0] idx
);

    always_comb begin
        found = 1'b0;
        idx   = '0;
        // Scanning downward lets the lowest set bit be the last assignment.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                idx   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/rs_param.sv
// Parametrised reservation station.
// Holds renamed instructions until both operands are available, captures
// operands from NUM_CDB broadcast channels, and issues one ready instruction
// per cycle into a registered valid/ready output stage.
// Ports:
//   clk, rst          - clock, asynchronous active-low reset
//   rdy               - global enable; all state freezes when low
//   flush             - synchronous clear of all entries and the issue stage
//   disp_*            - dispatch request and instruction fields
//   cdb_valid/tag/value - packed broadcast channels, channel i at [i*W +: W]
//   iss_*             - issue stage towards the ALU
//   count             - occupied entries, excluding the issue register
module rs_param
    import rs_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int XLEN    = RS_XLEN,
    parameter int TAG_W   = RS_TAG_W,
    parameter int OP_W    = RS_OP_W,
    parameter int NUM_CDB = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rdy,
    input  logic                       flush,
    input  logic                       disp_valid,
    output logic                       disp_ready,
    input  logic [OP_W-1:0]            disp_op,
    input  logic [XLEN-1:0]            disp_vj,
    input  logic [XLEN-1:0]            disp_vk,
    input  logic                       disp_qj_busy,
    input  logic                       disp_qk_busy,
    input  logic [TAG_W-1:0]           disp_qj,
    input  logic [TAG_W-1:0]           disp_qk,
    input  logic [XLEN-1:0]            disp_imm,
    input  logic [TAG_W-1:0]           disp_rob,
    input  logic [NUM_CDB-1:0]         cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0]   cdb_tag,
    input  logic [NUM_CDB*XLEN-1:0]    cdb_value,
    output logic                       iss_valid,
    input  logic                       iss_ready,
    output logic [OP_W-1:0]            iss_op,
    output logic [XLEN-1:0]            iss_lv,
    output logic [XLEN-1:0]            iss_rv,
    output logic [XLEN-1:0]            iss_imm,
    output logic [TAG_W-1:0]           iss_rob,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] qj_busy_q;
    logic [DEPTH-1:0] qk_busy_q;
    logic [OP_W-1:0]  op_q  [DEPTH];
    logic [XLEN-1:0]  vj_q  [DEPTH];
    logic [XLEN-1:0]  vk_q  [DEPTH];
    logic [TAG_W-1:0] qj_q  [DEPTH];
    logic [TAG_W-1:0] qk_q  [DEPTH];
    logic [XLEN-1:0]  imm_q [DEPTH];
    logic [TAG_W-1:0] rob_q [DEPTH];
    logic [CW-1:0]    count_q;

    logic             iss_valid_q;
    logic [OP_W-1:0]  iss_op_q;
    logic [XLEN-1:0]  iss_lv_q;
    logic [XLEN-1:0]  iss_rv_q;
    logic [XLEN-1:0]  iss_imm_q;
    logic [TAG_W-1:0] iss_rob_q;

    logic [DEPTH-1:0] ready_vec;
    logic             alloc_found;
    logic [IW-1:0]    alloc_idx;
    logic             sel_found;
    logic [IW-1:0]    sel_idx;
    logic             disp_fire;
    logic             iss_load;

    logic             byp_j_hit;
    logic             byp_k_hit;
    logic [XLEN-1:0]  byp_j_val;
    logic [XLEN-1:0]  byp_k_val;
    logic             new_qj_busy;
    logic             new_qk_busy;
    logic [XLEN-1:0]  new_vj;
    logic [XLEN-1:0]  new_vk;

    assign ready_vec = busy_q & ~qj_busy_q & ~qk_busy_q;

    rs_find_first #(.N(DEPTH), .IW(IW)) u_alloc (
        .req   (~busy_q),
        .found (alloc_found),
        .idx   (alloc_idx)
    );

    rs_find_first #(.N(DEPTH), .IW(IW)) u_select (
        .req   (ready_vec),
        .found (sel_found),
        .idx   (sel_idx)
    );

    // Registered-state only: an entry freed this cycle does not raise it.
    assign disp_ready = (count_q != CW'(DEPTH));
    assign disp_fire  = disp_valid & disp_ready & alloc_found & ~flush;
    assign iss_load   = (~iss_valid_q | iss_ready) & sel_found;

    // Same-cycle bypass for the instruction being dispatched; lowest channel wins.
    always_comb begin
        byp_j_hit = 1'b0;
        byp_k_hit = 1'b0;
        byp_j_val = '0;
        byp_k_val = '0;
        for (int c = NUM_CDB - 1; c >= 0; c--) begin
            if (cdb_valid[c] && cdb_tag[c*TAG_W +: TAG_W] == disp_qj) begin
                byp_j_hit = 1'b1;
                byp_j_val = cdb_value[c*XLEN +: XLEN];
            end
            if (cdb_valid[c] && cdb_tag[c*TAG_W +: TAG_W] == disp_qk) begin
                byp_k_hit = 1'b1;
                byp_k_val = cdb_value[c*XLEN +: XLEN];
            end
        end
        new_qj_busy = disp_qj_busy & ~byp_j_hit;
        new_qk_busy = disp_qk_busy & ~byp_k_hit;
        new_vj      = (disp_qj_busy && byp_j_hit) ? byp_j_val : disp_vj;
        new_vk      = (disp_qk_busy && byp_k_hit) ? byp_k_val : disp_vk;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q      <= '0;
            qj_busy_q   <= '0;
            qk_busy_q   <= '0;
            count_q     <= '0;
            iss_valid_q <= 1'b0;
            iss_op_q    <= '0;
            iss_lv_q    <= '0;
            iss_rv_q    <= '0;
            iss_imm_q   <= '0;
            iss_rob_q   <= '0;
            for (int e = 0; e < DEPTH; e++) begin
                op_q[e]  <= '0;
                vj_q[e]  <= '0;
                vk_q[e]  <= '0;
                qj_q[e]  <= '0;
                qk_q[e]  <= '0;
                imm_q[e] <= '0;
                rob_q[e] <= '0;
            end
        end else if (rdy) begin
            if (flush) begin
                busy_q      <= '0;
                count_q     <= '0;
                iss_valid_q <= 1'b0;
            end else begin
                // Wakeup: descending scan so the lowest matching channel lands last.
                for (int e = 0; e < DEPTH; e++) begin
                    for (int c = NUM_CDB - 1; c >= 0; c--) begin
                        if (busy_q[e] && cdb_valid[c]) begin
                            if (qj_busy_q[e] && cdb_tag[c*TAG_W +: TAG_W] == qj_q[e]) begin
                                vj_q[e]      <= cdb_value[c*XLEN +: XLEN];
                                qj_busy_q[e] <= 1'b0;
                            end
                            if (qk_busy_q[e] && cdb_tag[c*TAG_W +: TAG_W] == qk_q[e]) begin
                                vk_q[e]      <= cdb_value[c*XLEN +: XLEN];
                                qk_busy_q[e] <= 1'b0;
                            end
                        end
                    end
                end

                if (iss_load) begin
                    busy_q[sel_idx] <= 1'b0;
                    iss_valid_q     <= 1'b1;
                    iss_op_q        <= op_q[sel_idx];
                    iss_lv_q        <= vj_q[sel_idx];
                    iss_rv_q        <= vk_q[sel_idx];
                    iss_imm_q       <= imm_q[sel_idx];
                    iss_rob_q       <= rob_q[sel_idx];
                end else if (iss_ready) begin
                    iss_valid_q <= 1'b0;
                end

                // The allocated slot is free, so it never collides with the issued one.
                if (disp_fire) begin
                    busy_q[alloc_idx]    <= 1'b1;
                    op_q[alloc_idx]      <= disp_op;
                    vj_q[alloc_idx]      <= new_vj;
                    vk_q[alloc_idx]      <= new_vk;
                    qj_busy_q[alloc_idx] <= new_qj_busy;
                    qk_busy_q[alloc_idx] <= new_qk_busy;
                    qj_q[alloc_idx]      <= disp_qj;
                    qk_q[alloc_idx]      <= disp_qk;
                    imm_q[alloc_idx]     <= disp_imm;
                    rob_q[alloc_idx]     <= disp_rob;
                end

                count_q <= count_q + CW'(disp_fire) - CW'(iss_load);
            end
        end
    end

    assign iss_valid = iss_valid_q;
    assign iss_op    = iss_op_q;
    assign iss_lv    = iss_lv_q;
    assign iss_rv    = iss_rv_q;
    assign iss_imm   = iss_imm_q;
    assign iss_rob   = iss_rob_q;
    assign count     = count_q;

endmodule

// File: tb/tb_rs_param.sv
// Directed testbench for rs_param at default parameters.
module tb_rs_param;
    import rs_pkg::*;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        flush;
    logic        disp_valid;
    logic        disp_ready;
    logic [3:0]  disp_op;
    logic [31:0] disp_vj;
    logic [31:0] disp_vk;
    logic        disp_qj_busy;
    logic        disp_qk_busy;
    logic [3:0]  disp_qj;
    logic [3:0]  disp_qk;
    logic [31:0] disp_imm;
    logic [3:0]  disp_rob;
    logic [1:0]  cdb_valid;
    logic [7:0]  cdb_tag;
    logic [63:0] cdb_value;
    logic        iss_valid;
    logic        iss_ready;
    logic [3:0]  iss_op;
    logic [31:0] iss_lv;
    logic [31:0] iss_rv;
    logic [31:0] iss_imm;
    logic [3:0]  iss_rob;
    logic [4:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    rs_param dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .flush        (flush),
        .disp_valid   (disp_valid),
        .disp_ready   (disp_ready),
        .disp_op      (disp_op),
        .disp_vj      (disp_vj),
        .disp_vk      (disp_vk),
        .disp_qj_busy (disp_qj_busy),
        .disp_qk_busy (disp_qk_busy),
        .disp_qj      (disp_qj),
        .disp_qk      (disp_qk),
        .disp_imm     (disp_imm),
        .disp_rob     (disp_rob),
        .cdb_valid    (cdb_valid),
        .cdb_tag      (cdb_tag),
        .cdb_value    (cdb_value),
        .iss_valid    (iss_valid),
        .iss_ready    (iss_ready),
        .iss_op       (iss_op),
        .iss_lv       (iss_lv),
        .iss_rv       (iss_rv),
        .iss_imm      (iss_imm),
        .iss_rob      (iss_rob),
        .count        (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input logic [3:0] op, input logic [31:0] vj, input logic [31:0] vk,
                        input logic qjb, input logic [3:0] qj,
                        input logic qkb, input logic [3:0] qk, input logic [3:0] rob);
        disp_valid   = 1'b1;
        disp_op      = op;
        disp_vj      = vj;
        disp_vk      = vk;
        disp_qj_busy = qjb;
        disp_qj      = qj;
        disp_qk_busy = qkb;
        disp_qk      = qk;
        disp_imm     = {28'h0, rob};
        disp_rob     = rob;
    endtask

    task automatic cdb(input int ch, input logic [3:0] tag, input logic [31:0] val);
        cdb_valid[ch]          = 1'b1;
        cdb_tag[ch*4 +: 4]     = tag;
        cdb_value[ch*32 +: 32] = val;
    endtask

    initial begin
        rst = 1'b0; rdy = 1'b1; flush = 1'b0; iss_ready = 1'b1;
        disp_valid = 1'b0; disp_op = '0; disp_vj = '0; disp_vk = '0;
        disp_qj_busy = 1'b0; disp_qk_busy = 1'b0; disp_qj = '0; disp_qk = '0;
        disp_imm = '0; disp_rob = '0;
        cdb_valid = '0; cdb_tag = '0; cdb_value = '0;

        repeat (3) step();
        check("rst_count", 64'(count), 64'd0);
        check("rst_disp_ready", 64'(disp_ready), 64'd1);
        check("rst_iss_valid", 64'(iss_valid), 64'd0);
        check("rst_iss_lv", 64'(iss_lv), 64'd0);
        check("rst_iss_rob", 64'(iss_rob), 64'd0);
        rst = 1'b1;
        step();

        // Fully ready ADD: iss_valid one edge after the dispatch edge.
        disp(ALU_ADD, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 4'd3);
        step();
        disp_valid = 1'b0;
        check("t1_count_after_disp", 64'(count), 64'd1);
        check("t1_iss_valid_early", 64'(iss_valid), 64'd0);
        step();
        check("t1_iss_valid", 64'(iss_valid), 64'd1);
        check("t1_iss_lv", 64'(iss_lv), 64'd5);
        check("t1_iss_rv", 64'(iss_rv), 64'd7);
        check("t1_iss_rob", 64'(iss_rob), 64'd3);
        check("t1_iss_op", 64'(iss_op), 64'(ALU_ADD));
        check("t1_count", 64'(count), 64'd0);
        step();
        check("t1_iss_drop", 64'(iss_valid), 64'd0);

        // Wakeup through CDB channel 1.
        disp(ALU_SUB, 32'd0, 32'd2, 1'b1, 4'd6, 1'b0, 4'd0, 4'd4);
        step();
        disp_valid = 1'b0;
        step();
        step();
        cdb(1, 4'd6, 32'h1234);
        step();
        cdb_valid = '0;
        check("t2_not_yet", 64'(iss_valid), 64'd0);
        step();
        check("t2_iss_valid", 64'(iss_valid), 64'd1);
        check("t2_iss_lv", 64'(iss_lv), 64'h1234);
        check("t2_iss_rv", 64'(iss_rv), 64'd2);
        check("t2_iss_rob", 64'(iss_rob), 64'd4);
        step();

        // Dispatch bypass on qk from channel 0.
        disp(ALU_XOR, 32'd1, 32'd0, 1'b0, 4'd0, 1'b1, 4'd9, 4'd8);
        cdb(0, 4'd9, 32'hAA);
        step();
        disp_valid = 1'b0;
        cdb_valid = '0;
        step();
        check("t3_iss_valid", 64'(iss_valid), 64'd1);
        check("t3_iss_rv", 64'(iss_rv), 64'hAA);
        check("t3_iss_lv", 64'(iss_lv), 64'd1);
        step();

        // Both channels carry the same tag: channel 0 wins.
        disp(ALU_OR, 32'd0, 32'd3, 1'b1, 4'd5, 1'b0, 4'd0, 4'd7);
        step();
        disp_valid = 1'b0;
        cdb(0, 4'd5, 32'h11);
        cdb(1, 4'd5, 32'h22);
        step();
        cdb_valid = '0;
        step();
        check("t3b_prio_lv", 64'(iss_lv), 64'h11);
        check("t3b_prio_rob", 64'(iss_rob), 64'd7);
        step();
        check("t3b_empty", 64'(iss_valid), 64'd0);

        // Simultaneous dispatch and issue keeps count unchanged.
        disp(ALU_AND, 32'd10, 32'd11, 1'b0, 4'd0, 1'b0, 4'd0, 4'd1);
        step();
        disp(ALU_AND, 32'd20, 32'd21, 1'b0, 4'd0, 1'b0, 4'd0, 4'd2);
        step();
        disp_valid = 1'b0;
        check("t_sim_count", 64'(count), 64'd1);
        check("t_sim_rob_a", 64'(iss_rob), 64'd1);
        step();
        check("t_sim_rob_b", 64'(iss_rob), 64'd2);
        check("t_sim_count_b", 64'(count), 64'd0);
        step();

        // Fill all 16 entries with qj pending on tag 10.
        iss_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i == 15) check("t4_ready_at_15", 64'(disp_ready), 64'd1);
            disp(ALU_ADD, 32'd0, 32'(i), 1'b1, 4'd10, 1'b0, 4'd0, 4'(i));
            step();
        end
        check("t4_full_count", 64'(count), 64'd16);
        check("t4_full_ready", 64'(disp_ready), 64'd0);
        disp(ALU_ADD, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd14);
        step();
        disp_valid = 1'b0;
        check("t4_blocked_count", 64'(count), 64'd16);
        cdb(0, 4'd10, 32'h55);
        step();
        cdb_valid = '0;
        step();
        check("t4_first_valid", 64'(iss_valid), 64'd1);
        check("t4_first_rob", 64'(iss_rob), 64'd0);
        check("t4_first_lv", 64'(iss_lv), 64'h55);
        check("t4_count15", 64'(count), 64'd15);
        for (int h = 0; h < 3; h++) begin
            step();
            check("t4_hold_valid", 64'(iss_valid), 64'd1);
            check("t4_hold_rob", 64'(iss_rob), 64'd0);
            check("t4_hold_rv", 64'(iss_rv), 64'd0);
            check("t4_hold_count", 64'(count), 64'd15);
        end
        iss_ready = 1'b1;
        for (int k = 1; k < 16; k++) begin
            step();
            check("t4_drain_rob", 64'(iss_rob), 64'(k));
            check("t4_drain_rv", 64'(iss_rv), 64'(k));
            check("t4_drain_count", 64'(count), 64'(15 - k));
        end
        step();
        check("t4_drained", 64'(iss_valid), 64'd0);

        // Flush with 10 entries and a held issue slot.
        iss_ready = 1'b0;
        disp(ALU_SLT, 32'd1, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0, 4'd15);
        step();
        for (int i = 0; i < 10; i++) begin
            disp(ALU_ADD, 32'd0, 32'd0, 1'b1, 4'd12, 1'b0, 4'd0, 4'(i));
            step();
        end
        check("t5_count10", 64'(count), 64'd10);
        check("t5_iss_valid", 64'(iss_valid), 64'd1);
        check("t5_iss_rob", 64'(iss_rob), 64'd15);
        disp(ALU_ADD, 32'd3, 32'd4, 1'b0, 4'd0, 1'b0, 4'd0, 4'd13);
        flush = 1'b1;
        step();
        flush = 1'b0;
        disp_valid = 1'b0;
        check("t5_flush_count", 64'(count), 64'd0);
        check("t5_flush_valid", 64'(iss_valid), 64'd0);
        check("t5_flush_ready", 64'(disp_ready), 64'd1);
        iss_ready = 1'b1;
        cdb(0, 4'd12, 32'h66);
        step();
        cdb_valid = '0;
        step();
        step();
        check("t5_no_ghost_valid", 64'(iss_valid), 64'd0);
        check("t5_no_ghost_count", 64'(count), 64'd0);

        // rdy low freezes dispatch and capture.
        disp(ALU_SRA, 32'd0, 32'h77, 1'b1, 4'd8, 1'b0, 4'd0, 4'd2);
        step();
        rdy = 1'b0;
        disp(ALU_ADD, 32'd3, 32'd3, 1'b0, 4'd0, 1'b0, 4'd0, 4'd9);
        cdb(0, 4'd8, 32'h99);
        for (int r = 0; r < 4; r++) begin
            step();
            check("t6_frozen_count", 64'(count), 64'd1);
            check("t6_frozen_valid", 64'(iss_valid), 64'd0);
        end
        rdy = 1'b1;
        disp_valid = 1'b0;
        cdb_valid = '0;
        step();
        step();
        check("t6_no_capture_valid", 64'(iss_valid), 64'd0);
        check("t6_no_capture_count", 64'(count), 64'd1);
        cdb(0, 4'd8, 32'h99);
        step();
        cdb_valid = '0;
        step();
        check("t6_resume_valid", 64'(iss_valid), 64'd1);
        check("t6_resume_lv", 64'(iss_lv), 64'h99);
        check("t6_resume_rv", 64'(iss_rv), 64'h77);
        check("t6_resume_rob", 64'(iss_rob), 64'd2);
        step();

        // Asynchronous reset mid-operation.
        iss_ready = 1'b0;
        disp(ALU_SLTU, 32'd4, 32'd5, 1'b0, 4'd0, 1'b0, 4'd0, 4'd5);
        step();
        disp(ALU_ADD, 32'd0, 32'd0, 1'b1, 4'd1, 1'b0, 4'd0, 4'd6);
        step();
        disp_valid = 1'b0;
        check("t7_pre_valid", 64'(iss_valid), 64'd1);
        check("t7_pre_count", 64'(count), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check("t7_rst_valid", 64'(iss_valid), 64'd0);
        check("t7_rst_count", 64'(count), 64'd0);
        check("t7_rst_rob", 64'(iss_rob), 64'd0);
        check("t7_rst_ready", 64'(disp_ready), 64'd1);
        step();
        rst = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
